instr_prefetch_queue: RTL and testbench



---
 rtl/arch_defines.sv | 11 +
 rtl/fifo_sync.sv | 53 +++++
 rtl/instr_prefetch_queue.sv | 79 +++++++
 tb/tb_instr_prefetch_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arch_defines.sv
// Shared architectural constants and the prefetch queue entry layout.
package arch_defines;
  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; head is read combinationally.
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: fetch address generation, 1-cycle read latency capture,
// and a DEPTH-entry {pc, instr} queue feeding the issue register.
module instr_prefetch_queue
  import arch_defines::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             mem_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic [PC_W-1:0]  issue_pc,
  output logic [CNT_W-1:0] count
);
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;

  logic             w_push, w_pop, w_full, w_empty, w_room;
  logic [CNT_W:0]   w_occ;
  fetch_entry_t     w_wentry, w_head;

  // The outstanding request counts against capacity so its response always fits.
  assign w_occ  = {1'b0, count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_room = !w_full && (w_occ < (CNT_W+1)'(DEPTH));

  assign mem_req  = !rst && !redirect && w_room;
  assign mem_addr = r_fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mem_req;
      if (mem_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
    end
  end

  assign w_push   = r_inflight && !redirect;
  assign w_pop    = issue_valid && !stall;
  assign w_wentry = '{pc: r_req_pc, instr: mem_rdata};

  fifo_sync #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Redirect squashes the head in the same cycle it flushes the queue.
  assign issue_valid = !w_empty && !redirect;
  assign issue_instr = issue_valid ? w_head.instr : NOP_INSTR;
  assign issue_pc    = issue_valid ? w_head.pc    : '0;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue; memory returns addr+100 one cycle later.
module tb_instr_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr, mem_rdata;
  logic        issue_valid;
  logic [31:0] issue_instr, issue_pc;
  logic [2:0]  count;
  logic [31:0] r_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) r_mem <= mem_addr + 32'd100;
  assign mem_rdata = r_mem;

  instr_prefetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc), .count(count)
  );

  // Leaves the bench 1ns into cycle C0 after reset release.
  task automatic do_reset;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    rst = 0; #1;
  endtask

  task automatic test_reset;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0h expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %0h expected 0", issue_valid); end
    checks++; if (issue_instr !== 32'h0) begin errors++; $display("FAIL rst_issue_instr: got %0h expected 0", issue_instr); end
    checks++; if (issue_pc !== 32'h0) begin errors++; $display("FAIL rst_issue_pc: got %0h expected 0", issue_pc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    @(negedge clk); rst = 0; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL c0_mem_req: got %0h expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL c0_mem_addr: got %0h expected 0", mem_addr); end
  endtask

  task automatic test_stream;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(k)) begin errors++; $display("FAIL stream_req c%0d: got req=%0h addr=%0h expected req=1 addr=%0h", k, mem_req, mem_addr, k); end
      if (k < 2) begin
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d: got %0h expected 0", k, issue_valid); end
      end else begin
        checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'(k-2) || issue_instr !== 32'(k-2+100))
          begin errors++; $display("FAIL stream_issue c%0d: got v=%0h pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h", k, issue_valid, issue_pc, issue_instr, k-2, k-2+100); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count c%0d: got %0d expected 1", k, count); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); stall = 1; #1;
    for (int k = 3; k <= 11; k++) begin @(negedge clk); #1; end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_mem_req: got %0h expected 0", mem_req); end
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h0) begin errors++; $display("FAIL stall_head: got v=%0h pc=%0h expected v=1 pc=0", issue_valid, issue_pc); end
    @(negedge clk); stall = 0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL unstall_req_c12: got %0h expected 0", mem_req); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'(k) || issue_instr !== 32'(k+100))
        begin errors++; $display("FAIL unstall_issue %0d: got v=%0h pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h", k, issue_valid, issue_pc, issue_instr, k, k+100); end
      if (k == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin errors++; $display("FAIL unstall_resume: got req=%0h addr=%0h expected req=1 addr=4", mem_req, mem_addr); end
      end
    end
  endtask

  task automatic test_redirect;
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); stall = 1; #1;
    @(negedge clk); #1;
    @(negedge clk); redirect = 1; redirect_pc = 32'h40; #1;
    checks++; if (issue_valid !== 1'b0 || issue_instr !== 32'h0) begin errors++; $display("FAIL redir_squash: got v=%0h instr=%0h expected v=0 instr=0", issue_valid, issue_instr); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %0h expected 0", mem_req); end
    @(negedge clk); redirect = 0; stall = 0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_flush: got %0d expected 0", count); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL redir_req: got req=%0h addr=%0h expected req=1 addr=40", mem_req, mem_addr); end
    @(negedge clk); #1;
    checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL redir_stale: got count=%0d v=%0h expected count=0 v=0", count, issue_valid); end
    @(negedge clk); #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40 || issue_instr !== 32'hA4)
      begin errors++; $display("FAIL redir_issue: got v=%0h pc=%0h instr=%0h expected v=1 pc=40 instr=a4", issue_valid, issue_pc, issue_instr); end
  endtask

  task automatic test_redirect_stall;
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); stall = 1; #1;
    for (int k = 3; k <= 5; k++) begin @(negedge clk); #1; end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL rs_full: got %0d expected 4", count); end
    @(negedge clk); redirect = 1; redirect_pc = 32'h80; #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rs_squash: got %0h expected 0", issue_valid); end
    @(negedge clk); redirect = 0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rs_flush: got %0d expected 0", count); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL rs_req: got req=%0h addr=%0h expected req=1 addr=80", mem_req, mem_addr); end
    stall = 0;
  endtask

  task automatic test_mid_reset;
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); stall = 1; #1;
    @(negedge clk); #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL mr_pre_count: got %0d expected 2", count); end
    rst = 1; #1;
    checks++; if (count !== 3'd0 || issue_valid !== 1'b0 || issue_instr !== 32'h0 || issue_pc !== 32'h0)
      begin errors++; $display("FAIL mr_async_issue: got count=%0d v=%0h instr=%0h pc=%0h expected all 0", count, issue_valid, issue_instr, issue_pc); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL mr_async_mem: got req=%0h addr=%0h expected 0 0", mem_req, mem_addr); end
    @(negedge clk); rst = 0; stall = 0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL mr_restart: got req=%0h addr=%0h expected req=1 addr=0", mem_req, mem_addr); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h0 || issue_instr !== 32'd100)
      begin errors++; $display("FAIL mr_first_issue: got v=%0h pc=%0h instr=%0h expected v=1 pc=0 instr=64", issue_valid, issue_pc, issue_instr); end
  endtask

  task automatic test_wrap;
    do_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk); redirect = 0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_req0: got req=%0h addr=%0h expected req=1 addr=ffffffff", mem_req, mem_addr); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1: got req=%0h addr=%0h expected req=1 addr=0", mem_req, mem_addr); end
    @(negedge clk); #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'hFFFF_FFFF || issue_instr !== 32'd99)
      begin errors++; $display("FAIL wrap_issue0: got v=%0h pc=%0h instr=%0h expected v=1 pc=ffffffff instr=63", issue_valid, issue_pc, issue_instr); end
    @(negedge clk); #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h0 || issue_instr !== 32'd100)
      begin errors++; $display("FAIL wrap_issue1: got v=%0h pc=%0h instr=%0h expected v=1 pc=0 instr=64", issue_valid, issue_pc, issue_instr); end
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
